// File: rtl/fltadd_pkg.sv
// Shared types and constants for the half-precision adder sequencer:
// FSM state encoding, field positions of the 16-bit float and default memory map.
package fltadd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_ALIGN,
        S_ADD,
        S_STORE,
        S_DONE
    } state_t;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;

    localparam logic [7:0] OP_BASE_DEF   = 8'd8;
    localparam logic [7:0] RES_BASE_DEF  = 8'd12;
    localparam int         MAX_SHIFT_DEF = 11;

    localparam logic [2:0] LOAD_LAST  = 3'd4;
    localparam logic [2:0] STORE_LAST = 3'd1;

    // Hidden bit is always 1, including for exponent 0.
    function automatic logic [MANT_W:0] full_mant(input logic [15:0] h);
        return {1'b1, h[MANT_W-1:0]};
    endfunction

endpackage

// File: rtl/mant_aligner.sv
// Loadable 11-bit right shifter that shifts one bit per cycle until its
// down-counter expires; used to align the smaller-exponent mantissa.
module mant_aligner
    import fltadd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [MANT_W:0]   i_mant,
    input  logic [3:0]        i_shamt,
    output logic [MANT_W:0]   o_mant,
    output logic              o_zero
);

    logic [MANT_W:0] r_mant;
    logic [3:0]      r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mant <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_mant <= i_mant;
            r_cnt  <= i_shamt;
        end else if (r_cnt != 4'd0) begin
            r_mant <= r_mant >> 1;
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    assign o_mant = r_mant;
    // Asserted when the counter reaches zero at the coming edge, so the waiting
    // FSM can leave exactly after the final shift.
    assign o_zero = (r_cnt <= 4'd1);

endmodule

// File: rtl/fltadd_sequencer.sv
// Multi-cycle half-precision float adder controller: fetches two operands from
// memory, aligns exponents serially, adds with truncation and writes the sum back.
module fltadd_sequencer
    import fltadd_pkg::*;
#(
    parameter logic [7:0] OP_BASE   = OP_BASE_DEF,
    parameter logic [7:0] RES_BASE  = RES_BASE_DEF,
    parameter int         MAX_SHIFT = MAX_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] DataAddress,
    output logic       ReadMem,
    output logic       WriteMem,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    output logic       sub_err,
    output logic       exp_ovf
);

    localparam logic [EXP_W-1:0] SHIFT_CAP = EXP_W'(MAX_SHIFT);

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_cnt;
    logic [7:0]         r_b0, r_b1, r_b2;
    logic [MANT_W:0]    r_mant_big;
    logic [EXP_W-1:0]   r_exp3;
    logic [MANT_W-1:0]  r_mant3;
    logic               r_sign;
    logic               r_sub_err;
    logic               r_exp_ovf;

    logic [15:0]        w_op1, w_op2;
    logic [EXP_W-1:0]   w_e1, w_e2, w_d;
    logic               w_e1_ge;
    logic [3:0]         w_k;
    logic               w_sign_diff;
    logic               w_load_last;
    logic [MANT_W:0]    w_small;
    logic               w_align_zero;
    logic [MANT_W+1:0]  w_sum;
    logic [EXP_W:0]     w_exp_inc;

    // Operand 2 high byte is taken straight off the bus on the last LOAD cycle.
    assign w_op1       = {r_b1, r_b0};
    assign w_op2       = {DataOut, r_b2};
    assign w_e1        = w_op1[EXP_MSB:EXP_LSB];
    assign w_e2        = w_op2[EXP_MSB:EXP_LSB];
    assign w_e1_ge     = (w_e1 >= w_e2);
    assign w_d         = w_e1_ge ? (w_e1 - w_e2) : (w_e2 - w_e1);
    assign w_k         = (w_d > SHIFT_CAP) ? SHIFT_CAP[3:0] : w_d[3:0];
    assign w_sign_diff = w_op1[SIGN_BIT] ^ w_op2[SIGN_BIT];
    assign w_load_last = (r_state == S_LOAD) && (r_cnt == LOAD_LAST);

    mant_aligner u_aligner (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load_last),
        .i_mant  (w_e1_ge ? full_mant(w_op2) : full_mant(w_op1)),
        .i_shamt (w_k),
        .o_mant  (w_small),
        .o_zero  (w_align_zero)
    );

    assign w_sum     = {1'b0, r_mant_big} + {1'b0, w_small};
    assign w_exp_inc = {1'b0, r_exp3} + {{EXP_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_ARM;
            S_ARM:   if (!start) w_state_next = S_LOAD;
            S_LOAD: begin
                if (r_cnt == LOAD_LAST) begin
                    if (w_sign_diff)      w_state_next = S_STORE;
                    else if (w_k == 4'd0) w_state_next = S_ADD;
                    else                  w_state_next = S_ALIGN;
                end
            end
            S_ALIGN: if (w_align_zero) w_state_next = S_ADD;
            S_ADD:   w_state_next = S_STORE;
            S_STORE: if (r_cnt == STORE_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
        // Start acts as an abort/re-arm from anywhere.
        if (start) w_state_next = S_ARM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_mant_big <= '0;
            r_exp3     <= '0;
            r_mant3    <= '0;
            r_sign     <= 1'b0;
            r_sub_err  <= 1'b0;
            r_exp_ovf  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? 3'd0 : r_cnt + 3'd1;

            if (r_state == S_LOAD) begin
                case (r_cnt)
                    3'd1:    r_b0 <= DataOut;
                    3'd2:    r_b1 <= DataOut;
                    3'd3:    r_b2 <= DataOut;
                    default: ;
                endcase
            end

            if (start) begin
                r_sub_err <= 1'b0;
                r_exp_ovf <= 1'b0;
            end else if (w_load_last) begin
                if (w_sign_diff) begin
                    r_sub_err <= 1'b1;
                    r_mant3   <= '0;
                    r_exp3    <= '0;
                    r_sign    <= 1'b0;
                end else begin
                    r_exp3     <= w_e1_ge ? w_e1 : w_e2;
                    r_mant_big <= w_e1_ge ? full_mant(w_op1) : full_mant(w_op2);
                    r_sign     <= w_op1[SIGN_BIT];
                end
            end else if (r_state == S_ADD) begin
                if (w_sum[MANT_W+1]) begin
                    r_mant3   <= w_sum[MANT_W:1];
                    r_exp3    <= w_exp_inc[EXP_W-1:0];
                    r_exp_ovf <= w_exp_inc[EXP_W];
                end else begin
                    r_mant3 <= w_sum[MANT_W-1:0];
                end
            end
        end
    end

    // Strobes are gated by start so an abort suppresses the in-flight access.
    always_comb begin
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataAddress = 8'd0;
        DataIn      = 8'd0;
        if (r_state == S_LOAD && r_cnt < LOAD_LAST) begin
            ReadMem     = !start;
            DataAddress = OP_BASE + {5'd0, r_cnt};
        end else if (r_state == S_STORE) begin
            WriteMem    = !start;
            DataAddress = RES_BASE + {7'd0, r_cnt[0]};
            DataIn      = r_cnt[0] ? {r_sign, r_exp3, r_mant3[MANT_W-1:8]} : r_mant3[7:0];
        end
    end

    assign done    = (r_state == S_DONE);
    assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign sub_err = r_sub_err;
    assign exp_ovf = r_exp_ovf;

endmodule

// File: tb/tb_fltadd_sequencer.sv
// Scoreboard bench for fltadd_sequencer: directed operand pairs with hand-computed
// results, aborts by start and by reset, latency measured from the first operand read.
module tb_fltadd_sequencer;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       done, busy, ReadMem, WriteMem, sub_err, exp_ovf;
    logic [7:0] DataAddress, DataIn, DataOut;

    always #5 clk = ~clk;

    fltadd_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .DataOut     (DataOut),
        .sub_err     (sub_err),
        .exp_ovf     (exp_ovf)
    );

    logic [7:0] mem [0:255];
    logic       tb_we;
    logic [7:0] tb_addr, tb_data;

    always @(posedge clk) begin
        if (tb_we)         mem[tb_addr] <= tb_data;
        else if (WriteMem) mem[DataAddress] <= DataIn;
        if (ReadMem)       DataOut <= mem[DataAddress];
    end

    typedef struct {
        string      name;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       se;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t drv_e;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   load_cyc = 0;
    logic done_q = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // Monitor: on each rising done, pop the expected result and compare.
    always @(negedge clk) begin
        cycle++;
        if (ReadMem && WriteMem) begin
            errors++;
            $display("FAIL strobe_excl: ReadMem=1 WriteMem=1, required at most one");
        end
        if (ReadMem && DataAddress == 8'd8) load_cyc = cycle;
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done rose at cycle %0d, required no completion", cycle);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn %s: mem12=%h mem13=%h sub_err=%b exp_ovf=%b latency=%0d",
                         mon_e.name, mem[12], mem[13], sub_err, exp_ovf, cycle - load_cyc);
                check({mon_e.name, "_lo"},  mem[12], mon_e.lo);
                check({mon_e.name, "_hi"},  mem[13], mon_e.hi);
                check({mon_e.name, "_se"},  sub_err, mon_e.se);
                check({mon_e.name, "_ov"},  exp_ovf, mon_e.ov);
                check({mon_e.name, "_lat"}, cycle - load_cyc, mon_e.lat);
            end
        end
        done_q = done;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic load_ops(input logic [7:0] b0, b1, b2, b3);
        poke(8'd8, b0); poke(8'd9, b1); poke(8'd10, b2); poke(8'd11, b3);
        poke(8'd12, 8'hEE); poke(8'd13, 8'hEE);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: done=0 after 100 cycles, required 1", nm);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_load(input string nm);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ReadMem && (DataAddress == 8'd8);
        end
        if (!got) begin
            errors++;
            $display("FAIL %s_noload: first operand read not seen, required within 20 cycles", nm);
        end
    endtask

    task automatic push_exp(input string nm, input logic [7:0] lo, hi,
                            input logic se, ov, input int lat);
        drv_e.name = nm; drv_e.lo = lo; drv_e.hi = hi;
        drv_e.se = se; drv_e.ov = ov; drv_e.lat = lat;
        sb_q.push_back(drv_e);
    endtask

    task automatic run_op(input string nm, input logic [7:0] b0, b1, b2, b3,
                          input logic [7:0] lo, hi, input logic se, ov, input int lat);
        load_ops(b0, b1, b2, b3);
        push_exp(nm, lo, hi, se, ov, lat);
        pulse_start();
        wait_done(nm);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        tb_we = 1'b0; tb_addr = 8'd0; tb_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd",   ReadMem, 1'b0);
        check("rst_wr",   WriteMem, 1'b0);
        check("rst_addr", DataAddress, 8'd0);
        check("rst_din",  DataIn, 8'd0);
        check("rst_se",   sub_err, 1'b0);
        check("rst_ov",   exp_ovf, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        //     name           b0     b1     b2     b3     lo     hi    se    ov   lat
        run_op("one_one",    8'h00, 8'h3C, 8'h00, 8'h3C, 8'h00, 8'h40, 1'b0, 1'b0, 8);
        run_op("one_half",   8'h00, 8'h3C, 8'h00, 8'h38, 8'h00, 8'h3E, 1'b0, 1'b0, 9);
        run_op("half_one",   8'h00, 8'h38, 8'h00, 8'h3C, 8'h00, 8'h3E, 1'b0, 1'b0, 9);
        run_op("shift_cap",  8'h00, 8'h3C, 8'h00, 8'h04, 8'h00, 8'h3C, 1'b0, 1'b0, 19);
        run_op("mant_sum",   8'h00, 8'h3E, 8'h00, 8'h3D, 8'h80, 8'h41, 1'b0, 1'b0, 8);
        run_op("trunc_nc",   8'h01, 8'h3C, 8'h00, 8'h38, 8'h01, 8'h3E, 1'b0, 1'b0, 9);
        run_op("trunc_c",    8'h01, 8'h3C, 8'h00, 8'h3C, 8'h00, 8'h40, 1'b0, 1'b0, 8);
        run_op("neg_neg",    8'h00, 8'hBC, 8'h00, 8'hBC, 8'h00, 8'hC0, 1'b0, 1'b0, 8);
        run_op("exp_30",     8'h00, 8'h78, 8'h00, 8'h78, 8'h00, 8'h7C, 1'b0, 1'b0, 8);
        run_op("exp_wrap",   8'h00, 8'h7C, 8'h00, 8'h7C, 8'h00, 8'h00, 1'b0, 1'b1, 8);

        // Reset while parked in DONE clears the sticky flag.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_done_ov",   exp_ovf, 1'b0);
        check("rst_done_done", done, 1'b0);

        run_op("sign_diff",  8'h00, 8'h3C, 8'h00, 8'hBC, 8'h00, 8'h00, 1'b1, 1'b0, 7);

        // Abort by start during ALIGN, then rerun by releasing start.
        load_ops(8'h00, 8'h3C, 8'h00, 8'h04);
        pulse_start();
        wait_load("abort_start");
        repeat (7) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b1);
        check("abort_m12",  mem[12], 8'hEE);
        check("abort_m13",  mem[13], 8'hEE);
        push_exp("rerun", 8'h00, 8'h3C, 1'b0, 1'b0, 19);
        start = 1'b0;
        wait_done("rerun");

        // Abort by reset during ALIGN.
        load_ops(8'h00, 8'h3C, 8'h00, 8'h04);
        pulse_start();
        wait_load("abort_rst");
        repeat (7) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("arst_done", done, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rd",   ReadMem, 1'b0);
        check("arst_wr",   WriteMem, 1'b0);
        check("arst_addr", DataAddress, 8'd0);
        check("arst_din",  DataIn, 8'd0);
        repeat (25) @(negedge clk);
        check("arst_m12",  mem[12], 8'hEE);
        check("arst_m13",  mem[13], 8'hEE);
        check("arst_idle", done, 1'b0);

        check("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
